// File: rtl/dispatch_arbiter.sv
// Round-robin dispatch of per-thread decoded instructions to RS/BRANCH/LOAD stations,
// gated by per-station credit counters; losers are stalled combinationally.
module dispatch_arbiter #(
    parameter int unsigned NUM_THREADS = 2,
    parameter int unsigned PAYLOAD_W   = 96,
    parameter int unsigned RS_DEPTH    = 8,
    parameter int unsigned BR_DEPTH    = 4,
    parameter int unsigned LD_DEPTH    = 4,
    parameter int unsigned TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_THREADS-1:0]           dec_valid_i,
    input  logic [2*NUM_THREADS-1:0]         dec_fu_sel_i,
    input  logic [PAYLOAD_W*NUM_THREADS-1:0] dec_payload_i,
    output logic [NUM_THREADS-1:0]           stall_o,
    output logic                             rs_valid_o,
    output logic                             br_valid_o,
    output logic                             ld_valid_o,
    output logic                             none_valid_o,
    output logic [PAYLOAD_W-1:0]             disp_payload_o,
    output logic [TID_W-1:0]                 disp_tid_o,
    input  logic                             rs_cr_ret_i,
    input  logic                             br_cr_ret_i,
    input  logic                             ld_cr_ret_i,
    input  logic                             flush_i,
    output logic                             credit_err_o
);

    localparam int unsigned RS_CW = $clog2(RS_DEPTH + 1);
    localparam int unsigned BR_CW = $clog2(BR_DEPTH + 1);
    localparam int unsigned LD_CW = $clog2(LD_DEPTH + 1);
    localparam logic [RS_CW-1:0] RS_FULL = RS_CW'(RS_DEPTH);
    localparam logic [BR_CW-1:0] BR_FULL = BR_CW'(BR_DEPTH);
    localparam logic [LD_CW-1:0] LD_FULL = LD_CW'(LD_DEPTH);

    logic [RS_CW-1:0] rs_cnt_q, rs_cnt_d;
    logic [BR_CW-1:0] br_cnt_q, br_cnt_d;
    logic [LD_CW-1:0] ld_cnt_q, ld_cnt_d;
    logic [TID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [NUM_THREADS-1:0] elig;
    logic [NUM_THREADS-1:0] grant;
    logic                   grant_any;
    logic [TID_W-1:0]       win_tid;
    logic [1:0]             win_sel;
    logic [PAYLOAD_W-1:0]   win_payload;
    logic                   rs_take, br_take, ld_take;
    logic                   err_set;
    int unsigned            idx;

    always_comb begin
        for (int t = 0; t < int'(NUM_THREADS); t++) begin
            case (dec_fu_sel_i[2*t +: 2])
                2'd0:    elig[t] = dec_valid_i[t] && (rs_cnt_q != '0);
                2'd1:    elig[t] = dec_valid_i[t] && (br_cnt_q != '0);
                2'd2:    elig[t] = dec_valid_i[t] && (ld_cnt_q != '0);
                default: elig[t] = dec_valid_i[t];
            endcase
        end
    end

    always_comb begin
        grant_any = 1'b0;
        win_tid   = '0;
        idx       = 0;
        grant     = '0;
        for (int i = 0; i < int'(NUM_THREADS); i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_THREADS;
            if (!grant_any && elig[idx]) begin
                grant_any = 1'b1;
                win_tid   = TID_W'(idx);
            end
        end
        // Flush and reset suppress the grant, so every valid thread reads as stalled.
        if (flush_i || rst) begin
            grant_any = 1'b0;
        end
        if (grant_any) begin
            grant[win_tid] = 1'b1;
        end
        win_sel     = dec_fu_sel_i[2*int'(win_tid) +: 2];
        win_payload = dec_payload_i[int'(win_tid)*PAYLOAD_W +: PAYLOAD_W];
        stall_o     = dec_valid_i & ~grant;

        if (!grant_any) begin
            rr_ptr_d = rr_ptr_q;
        end else if (int'(win_tid) == int'(NUM_THREADS) - 1) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = win_tid + 1'b1;
        end
    end

    always_comb begin
        rs_take = grant_any && (win_sel == 2'd0);
        br_take = grant_any && (win_sel == 2'd1);
        ld_take = grant_any && (win_sel == 2'd2);

        // A same-cycle take and return cancel; a lone return at full is dropped.
        rs_cnt_d = rs_cnt_q;
        if (rs_take && !rs_cr_ret_i) begin
            rs_cnt_d = rs_cnt_q - 1'b1;
        end else if (!rs_take && rs_cr_ret_i && rs_cnt_q != RS_FULL) begin
            rs_cnt_d = rs_cnt_q + 1'b1;
        end
        br_cnt_d = br_cnt_q;
        if (br_take && !br_cr_ret_i) begin
            br_cnt_d = br_cnt_q - 1'b1;
        end else if (!br_take && br_cr_ret_i && br_cnt_q != BR_FULL) begin
            br_cnt_d = br_cnt_q + 1'b1;
        end
        ld_cnt_d = ld_cnt_q;
        if (ld_take && !ld_cr_ret_i) begin
            ld_cnt_d = ld_cnt_q - 1'b1;
        end else if (!ld_take && ld_cr_ret_i && ld_cnt_q != LD_FULL) begin
            ld_cnt_d = ld_cnt_q + 1'b1;
        end

        err_set = (!rs_take && rs_cr_ret_i && rs_cnt_q == RS_FULL) ||
                  (!br_take && br_cr_ret_i && br_cnt_q == BR_FULL) ||
                  (!ld_take && ld_cr_ret_i && ld_cnt_q == LD_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_cnt_q       <= RS_FULL;
            br_cnt_q       <= BR_FULL;
            ld_cnt_q       <= LD_FULL;
            rr_ptr_q       <= '0;
            rs_valid_o     <= 1'b0;
            br_valid_o     <= 1'b0;
            ld_valid_o     <= 1'b0;
            none_valid_o   <= 1'b0;
            disp_payload_o <= '0;
            disp_tid_o     <= '0;
            credit_err_o   <= 1'b0;
        end else begin
            rs_cnt_q     <= rs_cnt_d;
            br_cnt_q     <= br_cnt_d;
            ld_cnt_q     <= ld_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            rs_valid_o   <= rs_take;
            br_valid_o   <= br_take;
            ld_valid_o   <= ld_take;
            none_valid_o <= grant_any && (win_sel == 2'd3);
            credit_err_o <= credit_err_o | err_set;
            if (grant_any) begin
                disp_payload_o <= win_payload;
                disp_tid_o     <= win_tid;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_arbiter.sv
// Scoreboard bench for dispatch_arbiter: directed vectors push expected dispatches,
// a negedge monitor pops and compares whenever a station valid is presented.
module tb_dispatch_arbiter;
    localparam int NT = 2;
    localparam int PW = 96;

    logic              clk = 1'b0;
    logic              rst;
    logic [NT-1:0]     dec_valid_i;
    logic [2*NT-1:0]   dec_fu_sel_i;
    logic [PW*NT-1:0]  dec_payload_i;
    logic [NT-1:0]     stall_o;
    logic              rs_valid_o, br_valid_o, ld_valid_o, none_valid_o;
    logic [PW-1:0]     disp_payload_o;
    logic [0:0]        disp_tid_o;
    logic              rs_cr_ret_i, br_cr_ret_i, ld_cr_ret_i, flush_i;
    logic              credit_err_o;

    dispatch_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .dec_valid_i    (dec_valid_i),
        .dec_fu_sel_i   (dec_fu_sel_i),
        .dec_payload_i  (dec_payload_i),
        .stall_o        (stall_o),
        .rs_valid_o     (rs_valid_o),
        .br_valid_o     (br_valid_o),
        .ld_valid_o     (ld_valid_o),
        .none_valid_o   (none_valid_o),
        .disp_payload_o (disp_payload_o),
        .disp_tid_o     (disp_tid_o),
        .rs_cr_ret_i    (rs_cr_ret_i),
        .br_cr_ret_i    (br_cr_ret_i),
        .ld_cr_ret_i    (ld_cr_ret_i),
        .flush_i        (flush_i),
        .credit_err_o   (credit_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    fu;
        logic [PW-1:0] pl;
        logic [0:0]    tid;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    int         seq   = 0;
    exp_t       me;
    logic [3:0] mv;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mv = {none_valid_o, ld_valid_o, br_valid_o, rs_valid_o};
            if (mv != 4'b0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_dispatch: got valids %b want none", mv);
                end else begin
                    me = sb.pop_front();
                    check("disp_valids", 128'(mv), 128'(4'b0001 << me.fu));
                    check("disp_payload", 128'(disp_payload_o), 128'(me.pl));
                    check("disp_tid", 128'(disp_tid_o), 128'(me.tid));
                end
            end else if (sb.size() != 0) begin
                me = sb.pop_front();
                total++;
                bad++;
                $display("FAIL missing_dispatch: got no valid want fu=%0d tid=%0d", me.fu, me.tid);
            end
        end
    end

    task automatic drive(input logic [1:0] v, input logic [1:0] f0, input logic [1:0] f1);
        seq++;
        dec_valid_i   = v;
        dec_fu_sel_i  = {f1, f0};
        dec_payload_i = {32'hB1B1_0000 + 32'(seq), 64'(seq) << 8,
                         32'hA0A0_0000 + 32'(seq), 64'(seq) << 4};
    endtask

    // Inputs are set at posedge+1; stall checked at negedge; expectation queued after the edge.
    task automatic cyc(input string name, input logic [1:0] exp_stall, input bit g, input int tid);
        exp_t e;
        e = '0;
        @(negedge clk);
        check({name, "_stall"}, 128'(stall_o), 128'(exp_stall));
        if (g) begin
            e.fu  = dec_fu_sel_i[2*tid +: 2];
            e.pl  = dec_payload_i[tid*PW +: PW];
            e.tid = 1'(tid);
        end
        @(posedge clk);
        #1;
        if (g) sb.push_back(e);
    endtask

    task automatic idle_ret(input logic r, input logic b, input logic l);
        dec_valid_i = '0;
        rs_cr_ret_i = r;
        br_cr_ret_i = b;
        ld_cr_ret_i = l;
        cyc("ret", 2'b00, 1'b0, 0);
        rs_cr_ret_i = 1'b0;
        br_cr_ret_i = 1'b0;
        ld_cr_ret_i = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        check(name, 128'({none_valid_o, ld_valid_o, br_valid_o, rs_valid_o}), 128'(4'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        rs_cr_ret_i = 1'b0;
        br_cr_ret_i = 1'b0;
        ld_cr_ret_i = 1'b0;
        flush_i = 1'b0;
        drive(2'b11, 2'd0, 2'd0);
        #2;
        check("rst_stall", 128'(stall_o), 128'(2'b11));
        check_quiet("rst_valids");
        check("rst_payload", 128'(disp_payload_o), 128'(0));
        check("rst_tid", 128'(disp_tid_o), 128'(0));
        check("rst_err", 128'(credit_err_o), 128'(0));
        dec_valid_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Round robin, both threads to RS.
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 2'd0, 2'd0);
            cyc("rr", (k % 2 == 0) ? 2'b10 : 2'b01, 1'b1, k % 2);
        end

        // Reset in the middle of a dispatch.
        drive(2'b11, 2'd0, 2'd0);
        cyc("rst_mid", 2'b10, 1'b0, 0);
        check("pre_rst_valid", 128'(rs_valid_o), 128'(1));
        rst = 1'b1;
        #1;
        check_quiet("rst_mid_valids");
        check("rst_mid_err", 128'(credit_err_o), 128'(0));
        dec_valid_i = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // LD credit exhaust; RS from thread 1 still passes.
        for (int k = 0; k < 4; k++) begin
            drive(2'b01, 2'd2, 2'd0);
            cyc("ld_fill", 2'b00, 1'b1, 0);
        end
        for (int k = 0; k < 2; k++) begin
            drive(2'b11, 2'd2, 2'd0);
            cyc("ld_held", 2'b01, 1'b1, 1);
        end
        drive(2'b01, 2'd2, 2'd0);
        ld_cr_ret_i = 1'b1;
        cyc("ld_ret", 2'b01, 1'b0, 0);
        ld_cr_ret_i = 1'b0;
        cyc("ld_after_ret", 2'b00, 1'b1, 0);

        // BR return coinciding with a blocked BR request.
        for (int k = 0; k < 4; k++) begin
            drive(2'b01, 2'd1, 2'd0);
            cyc("br_fill", 2'b00, 1'b1, 0);
        end
        drive(2'b01, 2'd1, 2'd0);
        br_cr_ret_i = 1'b1;
        cyc("br_simul", 2'b01, 1'b0, 0);
        br_cr_ret_i = 1'b0;
        cyc("br_next", 2'b00, 1'b1, 0);
        cyc("br_zero", 2'b01, 1'b0, 0);

        // Drain RS (6 left), then flush and NONE with every credit at 0.
        for (int k = 0; k < 6; k++) begin
            drive(2'b01, 2'd0, 2'd0);
            cyc("rs_drain", 2'b00, 1'b1, 0);
        end
        drive(2'b01, 2'd0, 2'd0);
        cyc("rs_empty", 2'b01, 1'b0, 0);
        drive(2'b01, 2'd3, 2'd0);
        cyc("none0", 2'b00, 1'b1, 0);
        drive(2'b11, 2'd3, 2'd3);
        flush_i = 1'b1;
        cyc("flush", 2'b11, 1'b0, 0);
        flush_i = 1'b0;
        check_quiet("flush_clear");
        cyc("lui", 2'b01, 1'b1, 1);
        dec_valid_i = '0;

        // RS overflow: refill to 8, one extra return sets the sticky error.
        for (int k = 0; k < 8; k++) idle_ret(1'b1, 1'b0, 1'b0);
        check("err_before", 128'(credit_err_o), 128'(0));
        idle_ret(1'b1, 1'b0, 1'b0);
        check("err_set", 128'(credit_err_o), 128'(1));
        idle_ret(1'b0, 1'b1, 1'b1);
        idle_ret(1'b0, 1'b0, 1'b0);
        check("err_sticky", 128'(credit_err_o), 128'(1));
        for (int k = 0; k < 8; k++) begin
            drive(2'b01, 2'd0, 2'd0);
            cyc("rs_cap_fill", 2'b00, 1'b1, 0);
        end
        drive(2'b01, 2'd0, 2'd0);
        cyc("rs_cap", 2'b01, 1'b0, 0);
        check("err_still", 128'(credit_err_o), 128'(1));
        dec_valid_i = '0;
        cyc("tail", 2'b00, 1'b0, 0);
        cyc("tail", 2'b00, 1'b0, 0);
        check("sb_drained", 128'(sb.size()), 128'(0));

        rst = 1'b1;
        #1;
        check("err_cleared", 128'(credit_err_o), 128'(0));
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
